// File: rtl/rgb_fade_pkg.sv
// Shared types and helpers for the RGB hue-wheel fade sequencer.
// Optional single-step feature: RGB_FADE_SINGLE_STEP_EN.
package rgb_fade_pkg;

  typedef enum logic [2:0] {
    S0, S1, S2, S3, S4, S5
  } sector_t;

  function automatic int duty_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic sector_t sector_next(input sector_t s);
    return (s == S5) ? S0 : sector_t'(s + 3'd1);
  endfunction

endpackage

// File: rtl/rgb_fade_if.sv
// Control/status bundle between the fade sequencer and its user.
// step_req exists only with RGB_FADE_SINGLE_STEP_EN.
interface rgb_fade_if #(
  parameter int W = 11
);

  logic         run;
`ifdef RGB_FADE_SINGLE_STEP_EN
  logic         step_req;
`endif
  logic [W-1:0] duty_r;
  logic [W-1:0] duty_g;
  logic [W-1:0] duty_b;
  logic [2:0]   sector;
  logic         period_wrap;

`ifdef RGB_FADE_SINGLE_STEP_EN
  modport master (
    output run, step_req,
    input  duty_r, duty_g, duty_b, sector, period_wrap
  );
  modport slave (
    input  run, step_req,
    output duty_r, duty_g, duty_b, sector, period_wrap
  );
`else
  modport master (
    output run,
    input  duty_r, duty_g, duty_b, sector, period_wrap
  );
  modport slave (
    input  run,
    output duty_r, duty_g, duty_b, sector, period_wrap
  );
`endif

endinterface

// File: rtl/rgb_fade_sequencer_divider.sv
// PWM period counter plus step divider producing the per-step tick.
// period_wrap is combinational from the counter; step_tick likewise.
module period_tick_divider
  import rgb_fade_pkg::*;
#(
  parameter int PWM_COUNTER_MAX = 1200,
  parameter int STEP_PERIODS    = 10
) (
  input  logic clk,
  input  logic rst,
  output logic period_wrap_o,
  output logic step_tick_o
);

  localparam int CW = duty_width(PWM_COUNTER_MAX);
  localparam int DW = duty_width(STEP_PERIODS);
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_COUNTER_MAX - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_PERIODS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          div_last;

  assign period_wrap_o = (cnt_q == CNT_LAST);
  assign div_last      = (div_q == DIV_LAST);
  assign step_tick_o   = period_wrap_o && div_last;

  always_comb begin
    cnt_d = period_wrap_o ? '0 : cnt_q + CW'(1);
    div_d = div_q;
    if (period_wrap_o) begin
      div_d = div_last ? '0 : div_q + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Six-sector hue-wheel fade: ramps one PWM duty per step, period aligned.
// Define RGB_FADE_SINGLE_STEP_EN to add step_req single stepping.
module rgb_fade_sequencer
  import rgb_fade_pkg::*;
#(
  parameter int PWM_COUNTER_MAX = 1200,
  parameter int STEP_PERIODS    = 10,
  parameter int DUTY_STEP       = 12
) (
  input  logic       clk,
  input  logic       rst,
  rgb_fade_if.slave  bus
);

  localparam int W = duty_width(PWM_COUNTER_MAX);
  localparam logic [W:0]   MAX1  = (W+1)'(PWM_COUNTER_MAX);
  localparam logic [W-1:0] MAXW  = W'(PWM_COUNTER_MAX);
  localparam logic [W:0]   STEP1 = (W+1)'(DUTY_STEP);
  localparam logic [W-1:0] STEPW = W'(DUTY_STEP);

  logic         period_wrap;
  logic         step_tick;
  logic         step_en;
  sector_t      sector_q;
  logic [W-1:0] r_q, g_q, b_q;
  logic [W-1:0] ch_cur, ch_d;
  logic [W:0]   sum;
  logic         rising;
  logic         done;

  period_tick_divider #(
    .PWM_COUNTER_MAX (PWM_COUNTER_MAX),
    .STEP_PERIODS    (STEP_PERIODS)
  ) u_div (
    .clk           (clk),
    .rst           (rst),
    .period_wrap_o (period_wrap),
    .step_tick_o   (step_tick)
  );

  // Only the ramping channel of the current sector is ever touched.
  always_comb begin
    ch_cur = r_q;
    rising = 1'b0;
    unique case (sector_q)
      S0: begin ch_cur = g_q; rising = 1'b1; end
      S1: ch_cur = r_q;
      S2: begin ch_cur = b_q; rising = 1'b1; end
      S3: ch_cur = g_q;
      S4: begin ch_cur = r_q; rising = 1'b1; end
      S5: ch_cur = b_q;
      default: ;
    endcase
    sum = {1'b0, ch_cur} + STEP1;
    if (rising) begin
      done = (sum >= MAX1);
      ch_d = done ? MAXW : sum[W-1:0];
    end else begin
      done = ({1'b0, ch_cur} <= STEP1);
      ch_d = done ? '0 : ch_cur - STEPW;
    end
  end

`ifdef RGB_FADE_SINGLE_STEP_EN
  logic pend_q;
  assign step_en = step_tick && (bus.run || pend_q);
`else
  assign step_en = step_tick && bus.run;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sector_q <= S0;
      r_q      <= MAXW;
      g_q      <= '0;
      b_q      <= '0;
`ifdef RGB_FADE_SINGLE_STEP_EN
      pend_q   <= 1'b0;
`endif
    end else begin
      if (step_en) begin
        unique case (sector_q)
          S0, S3:  g_q <= ch_d;
          S1, S4:  r_q <= ch_d;
          S2, S5:  b_q <= ch_d;
          default: ;
        endcase
        if (done) begin
          sector_q <= sector_next(sector_q);
        end
      end
`ifdef RGB_FADE_SINGLE_STEP_EN
      // Flag is a one-shot: set only while halted, consumed by one tick.
      if (bus.run) begin
        pend_q <= 1'b0;
      end else if (step_tick && pend_q) begin
        pend_q <= 1'b0;
      end else if (bus.step_req) begin
        pend_q <= 1'b1;
      end
`endif
    end
  end

  assign bus.duty_r      = r_q;
  assign bus.duty_g      = g_q;
  assign bus.duty_b      = b_q;
  assign bus.sector      = sector_q;
  assign bus.period_wrap = period_wrap;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Randomized bench for rgb_fade_sequencer against a hue-wheel model.
// Single-step checks are built when RGB_FADE_SINGLE_STEP_EN is defined.
module tb_rgb_fade_sequencer;
  import rgb_fade_pkg::*;

  localparam int MAX = 10;
  localparam int SP  = 2;
  localparam int DS  = 3;
  localparam int W   = duty_width(MAX);

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   clk_run = 1'b0;

  always #5 if (clk_run) clk = ~clk;

  rgb_fade_if #(.W(W)) bus();

  rgb_fade_sequencer #(
    .PWM_COUNTER_MAX (MAX),
    .STEP_PERIODS    (SP),
    .DUTY_STEP       (DS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state: duties indexed R=0 G=1 B=2, k = cycle index since release.
  int m_duty[3];
  int m_sec;
  int k;
  bit m_pend;
  int ramp_ch[6] = '{1, 0, 2, 1, 0, 2};
  bit ramp_up[6] = '{1, 0, 1, 0, 1, 0};

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    m_duty[0] = MAX;
    m_duty[1] = 0;
    m_duty[2] = 0;
    m_sec     = 0;
    k         = 0;
    m_pend    = 1'b0;
  endtask

  task automatic apply_step();
    int c;
    c = ramp_ch[m_sec];
    if (ramp_up[m_sec]) begin
      if (m_duty[c] + DS >= MAX) begin
        m_duty[c] = MAX;
        m_sec = (m_sec + 1) % 6;
      end else begin
        m_duty[c] = m_duty[c] + DS;
      end
    end else begin
      if (m_duty[c] <= DS) begin
        m_duty[c] = 0;
        m_sec = (m_sec + 1) % 6;
      end else begin
        m_duty[c] = m_duty[c] - DS;
      end
    end
  endtask

  task automatic model_edge();
    bit tick;
    bit go;
    tick = ((k + 1) % (MAX * SP)) == 0;
    go   = tick && (bus.run || m_pend);
`ifdef RGB_FADE_SINGLE_STEP_EN
    if (bus.run) m_pend = 1'b0;
    else if (tick && m_pend) m_pend = 1'b0;
    else if (bus.step_req) m_pend = 1'b1;
`endif
    if (go) apply_step();
    k++;
  endtask

  task automatic check_all();
    chk("duty_r", bus.duty_r, m_duty[0]);
    chk("duty_g", bus.duty_g, m_duty[1]);
    chk("duty_b", bus.duty_b, m_duty[2]);
    chk("sector", bus.sector, m_sec);
    chk("period_wrap", bus.period_wrap, int'(((k + 1) % MAX) == 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_r"}, bus.duty_r, MAX);
    chk({pfx, "_g"}, bus.duty_g, 0);
    chk({pfx, "_b"}, bus.duty_b, 0);
    chk({pfx, "_sec"}, bus.sector, 0);
    chk({pfx, "_wrap"}, bus.period_wrap, 0);
  endtask

  // Called at a negedge; asserts rst mid-period, releases at next negedge.
  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  task automatic probe_first_step(input string pfx);
    repeat (21) begin
      cycle();
      if (k == 19) chk({pfx, "_pre_g"}, bus.duty_g, 0);
      if (k == 20) chk({pfx, "_step_g"}, bus.duty_g, 3);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wraps;
    bus.run = 1'b1;
`ifdef RGB_FADE_SINGLE_STEP_EN
    bus.step_req = 1'b0;
`endif
    #1 rst = 1'b1;
    #1 check_reset_vals("por");
    model_reset();
    #5 clk_run = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all();

    // Full wheel with run held high: 24 steps.
    repeat (480) begin
      cycle();
      if (k == 19)  chk("pre_step_g", bus.duty_g, 0);
      if (k == 20)  chk("first_step_g", bus.duty_g, 3);
      if (k == 80)  chk("s1_entry", bus.sector, 1);
      if (k == 160) chk("s2_r_zero", bus.duty_r, 0);
    end
    chk("wheel_wrap_sec", bus.sector, 0);
    chk("wheel_wrap_r", bus.duty_r, MAX);

    // Hold in S2 with B=6.
    n = 0;
    while (!(m_sec == 2 && m_duty[2] == 6) && n < 1000) begin
      cycle();
      n++;
    end
    if (n >= 1000) chk("hold_reach_timeout", 0, 1);
    bus.run = 1'b0;
    wraps = 0;
    repeat (100) begin
      cycle();
      wraps += int'(bus.period_wrap);
    end
    chk("hold_b", bus.duty_b, 6);
    chk("hold_wraps", wraps, 10);
    bus.run = 1'b1;
    n = 0;
    while (m_duty[2] != 9 && n < 40) begin
      cycle();
      n++;
    end
    chk("resume_b", bus.duty_b, 9);
    chk("resume_lat", n, 20);

    // Reset in the middle of a period while in S3.
    n = 0;
    while (m_sec != 3 && n < 400) begin
      cycle();
      n++;
    end
    if (n >= 400) chk("s3_reach_timeout", 0, 1);
    repeat (4) cycle();
    reset_pulse();
    probe_first_step("mid_rst");

    // Random run toggling, step requests and occasional resets.
    repeat (3000) begin
      if ($urandom_range(0, 29) == 0) bus.run = ~bus.run;
`ifdef RGB_FADE_SINGLE_STEP_EN
      bus.step_req = ($urandom_range(0, 14) == 0);
`endif
      if ($urandom_range(0, 499) == 0) reset_pulse();
      else cycle();
    end

`ifdef RGB_FADE_SINGLE_STEP_EN
    bus.run = 1'b0;
    bus.step_req = 1'b0;
    reset_pulse();
    repeat (41) begin
      bus.step_req = (k == 2 || k == 5);
      cycle();
      if (k == 20) chk("single_step_g", bus.duty_g, 3);
      if (k == 40) chk("single_once_g", bus.duty_g, 3);
    end
    bus.step_req = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
